timed_stimulus_source: RTL and testbench

Synthesizable stimulus stage on `source_clock` that accepts timed commands from the DPI-driven C++ test harness and replays them onto a valid/ready output stream. Each command carries a data word and a delay, given as the number of idle clocks before it is presented. Each emitted beat is tagged with a 64-bit cycle timemark so software can correlate output timing with the simulation time it reads back. It sits directly downstream of the test context interface and upstream of the DUT input port.

---
 rtl/timed_stimulus_source.sv | 120 ++++++++++++
 tb/tb_timed_stimulus_source.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/timed_stimulus_source.sv
// timed_stimulus_source: buffers timed {data, delay} commands and replays them onto a
// valid/ready stream, tagging each beat with the cycle count at which it was first presented.
module timed_stimulus_source #(
    parameter int DATA_W  = 32,
    parameter int DELAY_W = 16,
    parameter int DEPTH   = 8
) (
    input  logic                       source_clock,
    input  logic                       source_reset_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [DATA_W-1:0]          cmd_data,
    input  logic [DELAY_W-1:0]         cmd_delay,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [63:0]                out_timemark,
    output logic [$clog2(DEPTH+1)-1:0] fifo_level,
    output logic                       busy
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int ENT_W = DATA_W + DELAY_W;

    typedef enum logic [1:0] {IDLE, WAIT, SEND} state_t;

    state_t             state;
    logic [DELAY_W-1:0] cnt;
    logic [63:0]        cyc;

    logic [ENT_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [LVL_W-1:0]   count;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic [DATA_W-1:0]  head_data;
    logic [DELAY_W-1:0] head_delay;

    assign empty      = (count == '0);
    assign full       = (count == LVL_W'(DEPTH));
    assign cmd_ready  = !full;
    assign push       = cmd_valid && !full;
    // The FSM is the only reader: it pops from IDLE, or on a handshake to chain beats.
    assign pop        = !empty && ((state == IDLE) || ((state == SEND) && out_ready));
    assign {head_data, head_delay} = mem[rd_ptr];
    assign fifo_level = count;
    assign busy       = !empty || (state != IDLE);

    // NOTE: the storage array carries no reset; entries are only read once count says they
    // were written, and leaving it out of reset keeps it mappable onto plain RAM.
    always_ff @(posedge source_clock) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_data, cmd_delay};
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge source_clock or negedge source_reset_n) begin
        if (!source_reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + LVL_W'(1);
                2'b01:   count <= count - LVL_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge source_clock or negedge source_reset_n) begin
        if (!source_reset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            cyc          <= '0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_timemark <= '0;
        end else begin
            cyc <= cyc + 64'd1;
            if (pop) begin
                // out_data doubles as the hold register; it is only observed while out_valid is high
                out_data <= head_data;
                if (head_delay == '0) begin
                    state        <= SEND;
                    out_valid    <= 1'b1;
                    out_timemark <= cyc + 64'd1;
                end else begin
                    state     <= WAIT;
                    cnt       <= head_delay;
                    out_valid <= 1'b0;
                end
            end else begin
                case (state)
                    WAIT: begin
                        cnt <= cnt - DELAY_W'(1);
                        if (cnt == DELAY_W'(1)) begin
                            state        <= SEND;
                            out_valid    <= 1'b1;
                            out_timemark <= cyc + 64'd1;
                        end
                    end
                    SEND: begin
                        if (out_ready) begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_timed_stimulus_source.sv
// Self-checking bench for timed_stimulus_source: scoreboard of expected {data, timemark}
// beats, a table of isolated commands, and hand-written throughput/stall/reset sequences.
module tb_timed_stimulus_source;
    localparam int DATA_W  = 32;
    localparam int DELAY_W = 16;
    localparam int DEPTH   = 8;
    localparam int LVL_W   = $clog2(DEPTH + 1);

    logic               source_clock = 1'b0;
    logic               source_reset_n;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [DATA_W-1:0]  cmd_data;
    logic [DELAY_W-1:0] cmd_delay;
    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  out_data;
    logic [63:0]        out_timemark;
    logic [LVL_W-1:0]   fifo_level;
    logic               busy;

    timed_stimulus_source #(.DATA_W(DATA_W), .DELAY_W(DELAY_W), .DEPTH(DEPTH)) dut (
        .source_clock  (source_clock),
        .source_reset_n(source_reset_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_data      (cmd_data),
        .cmd_delay     (cmd_delay),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_timemark  (out_timemark),
        .fifo_level    (fifo_level),
        .busy          (busy)
    );

    always #5 source_clock = ~source_clock;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [63:0]       tm;
    } exp_t;

    typedef struct {
        logic [DATA_W-1:0]  data;
        logic [DELAY_W-1:0] delay;
        logic [63:0]        start;   // 0: push as soon as the previous beat drained
    } vec_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [63:0] tb_cyc;
    bit          in_beat;

    // Reference cycle count: 0 in the first cycle after reset release.
    always @(posedge source_clock or negedge source_reset_n) begin
        if (!source_reset_n) tb_cyc <= '0;
        else                 tb_cyc <= tb_cyc + 64'd1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Output monitor: checks rise cycle of each new beat and pops the scoreboard on handshake.
    always @(negedge source_clock) begin
        if (!source_reset_n) begin
            in_beat = 1'b0;
        end else begin
            if (out_valid && !in_beat) begin
                check("beat_expected", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) check("rise_cycle", tb_cyc, sb[0].tm);
            end
            if (out_valid && out_ready) begin
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check("out_data", 64'(out_data), 64'(e.data));
                    check("out_timemark", out_timemark, e.tm);
                end
                in_beat = 1'b0;
            end else begin
                in_beat = out_valid;
            end
        end
    end

    // Called just after a rising edge; returns the cycle number in which the command was accepted.
    task automatic push_cmd(input logic [DATA_W-1:0] d, input logic [DELAY_W-1:0] dl,
                            output logic [63:0] acc);
        logic rdy;
        int   n;
        n         = 0;
        acc       = '0;
        cmd_valid = 1'b1;
        cmd_data  = d;
        cmd_delay = dl;
        forever begin
            @(negedge source_clock);
            rdy = cmd_ready;
            acc = tb_cyc;
            @(posedge source_clock);
            #1;
            if (rdy) break;
            n++;
            if (n > 200) begin
                check("push_timeout", 64'd0, 64'd1);
                break;
            end
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_cycle(input logic [63:0] target);
        while (tb_cyc < target) begin
            @(posedge source_clock);
            #1;
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge source_clock);
            #1;
            n++;
        end
        check("drain", 64'(sb.size()), 64'd0);
    endtask

    vec_t        vec[6];
    logic [63:0] acc;
    logic [63:0] c0;
    logic [63:0] r;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vec[0] = '{32'hA5A5_0001, 16'd0,     64'd3};
        vec[1] = '{32'h0000_0011, 16'd5,     64'd10};
        vec[2] = '{32'hDEAD_BEEF, 16'd1,     64'd0};
        vec[3] = '{32'h0000_0007, 16'd2,     64'd0};
        vec[4] = '{32'hFFFF_FFFF, 16'd3,     64'd0};
        vec[5] = '{32'h0000_0033, 16'd65535, 64'd0};

        source_reset_n = 1'b0;
        cmd_valid      = 1'b0;
        cmd_data       = '0;
        cmd_delay      = '0;
        out_ready      = 1'b1;

        #3;
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_timemark", out_timemark, 64'd0);
        check("rst_fifo_level", 64'(fifo_level), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        @(negedge source_clock);
        @(negedge source_clock);
        source_reset_n = 1'b1;

        // Isolated commands: latency 2 + delay from accept, busy drops one cycle after handshake.
        for (int i = 0; i < 6; i++) begin
            @(posedge source_clock);
            #1;
            if (vec[i].start != 0) wait_cycle(vec[i].start);
            push_cmd(vec[i].data, vec[i].delay, acc);
            if (vec[i].start != 0) check("accept_cycle", acc, vec[i].start);
            sb.push_back('{vec[i].data, acc + 64'd2 + 64'(vec[i].delay)});
            drain(int'(vec[i].delay) + 20);
            @(negedge source_clock);
            check("busy_after_beat", 64'(busy), 64'd0);
        end

        // Back-to-back: four delay-0 commands give four consecutive beats.
        @(posedge source_clock);
        #1;
        for (int i = 1; i <= 4; i++) begin
            push_cmd(DATA_W'(i), '0, acc);
            if (i == 1) c0 = acc;
            sb.push_back('{DATA_W'(i), c0 + 64'd1 + 64'(i)});
        end
        drain(20);

        // Stall: hold out_ready low, FIFO fills behind the beat held in SEND.
        out_ready = 1'b0;
        @(posedge source_clock);
        #1;
        for (int i = 0; i < 9; i++) begin
            push_cmd(32'h5000_0000 + DATA_W'(i), '0, acc);
            if (i == 0) begin
                c0 = acc;
                sb.push_back('{32'h5000_0000, c0 + 64'd2});
            end
        end
        cmd_valid = 1'b1;
        cmd_data  = 32'h5000_0009;
        cmd_delay = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge source_clock);
            check("stall_cmd_ready", 64'(cmd_ready), 64'd0);
            check("stall_fifo_level", 64'(fifo_level), 64'd8);
            check("stall_out_valid", 64'(out_valid), 64'd1);
            check("stall_out_data", 64'(out_data), 64'h5000_0000);
            check("stall_out_timemark", out_timemark, c0 + 64'd2);
        end
        @(posedge source_clock);
        #1;
        cmd_valid = 1'b0;
        r = tb_cyc;
        for (int i = 1; i < 9; i++) begin
            sb.push_back('{32'h5000_0000 + DATA_W'(i), r + 64'(i)});
        end
        out_ready = 1'b1;
        drain(40);

        // Reset mid-delay: no beat ever appears, state clears asynchronously.
        @(posedge source_clock);
        #1;
        push_cmd(32'h0000_0022, 16'd100, acc);
        wait_cycle(acc + 64'd62);
        check("pre_reset_busy", 64'(busy), 64'd1);
        #2;
        source_reset_n = 1'b0;
        #1;
        check("async_fifo_level", 64'(fifo_level), 64'd0);
        check("async_busy", 64'(busy), 64'd0);
        check("async_out_valid", 64'(out_valid), 64'd0);
        check("async_cmd_ready", 64'(cmd_ready), 64'd1);
        @(negedge source_clock);
        @(negedge source_clock);
        source_reset_n = 1'b1;
        @(posedge source_clock);
        #1;
        push_cmd(32'h0000_0044, '0, acc);
        sb.push_back('{32'h0000_0044, acc + 64'd2});
        drain(20);

        // Make sure the aborted 0x22 never surfaces after its original deadline.
        repeat (60) @(posedge source_clock);
        #1;
        check("final_busy", 64'(busy), 64'd0);
        check("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
